tdc_enc_arbiter: RTL
====================

// Module: tdc_enc_arbiter
// PURPOSE
//  - Shares one combinational 8b->3b TDC encoder cell between N_CH fine-code requesters, using round-robin arbitration.
//  - Outputs tagged results {channel, code, bubble, error} on a valid/ready stream.
//  - Keeps a saturating error count per channel.
//  - Sits between the per-channel fine-TDC capture latches and the TDC event formatter.
// PARAMETERS
//  N_CH   4   number of requesting channels (2..16)
//  CH_W   2   channel-index width, = clog2(N_CH)
//  CNT_W  8   width of each per-channel error counter
// PORTS
//  clk        in   1          system clock
//  rst        in   1          synchronous active-high reset
//  enable     in   1          arbitration enable
//  level      in   2          error threshold; latched on IDLE->RUN; 0 is treated as 1
//  ch_req     in   N_CH       per-channel request; held until ack
//  ch_code    in   8*N_CH     per-channel 8b code; channel k is [8k+7:8k]; stable while req is high
//  ch_ack     out  N_CH       1-cycle grant pulse; code is captured on this edge
//  out_valid  out  1          result valid
//  out_ready  in   1          downstream accepts result
//  out_ch     out  CH_W       channel index of the result
//  out_code   out  3          encoded fine code (0 if out_error)
//  out_bubble out  1          bubble flag
//  out_error  out  1          error flag
//  cnt_clr    in   1          synchronous clear of all error counters
//  err_cnt    out  N_CH*CNT_W per-channel error counts
// BEHAVIOUR
//  - Reset: state=IDLE; ch_ack=0; out_valid=0; out_ch/out_code/out_bubble/out_error=0.
//    Stage-1 valid=0; rr pointer=N_CH-1, so ch0 wins first; lvl_q=1; err_cnt=0.
//  - FSM:
//    - IDLE -> RUN when enable=1; lvl_q <= (level==0)?1:level.
//    - RUN -> DRAIN when enable=0.
//    - DRAIN -> IDLE when stage-1 is empty and out_valid=0.
//    - DRAIN -> RUN when enable=1 again; lvl_q is not re-latched.
//    - No grants are issued in IDLE or DRAIN.
//  - Pipeline:
//    - Stage 1 is a register holding {ch, code}.
//    - The encoder cell is combinational on stage 1.
//    - Stage 2 is the output register.
//    - adv = !out_valid | out_ready.
//    - A grant is issued only in RUN when adv=1 and some ch_req is high.
//    - Stage 1 -> stage 2 moves only when adv=1.
//  - Latency: ack at edge t; out_valid high after edge t+1 (2 cycles req->result), with no backpressure.
//    Throughput is 1 result/cycle.
//  - Arbitration: search starts at ptr+1 and wraps modulo N_CH. The first requesting channel wins. ptr <= winner.
//    All N_CH requesting means strict rotation 0,1,..,N_CH-1,0.
//  - Encoder cell:
//    - R = index of highest set bit; R=0 if none of bits 7..1 is set.
//    - L = index of lowest set bit; L=7 if none of bits 0..6 is set.
//    - d = (R-L) mod 8.
//    - error = d>=lvl_q.
//    - bubble = d!=0.
//    - code = error ? 0 : (d<=1 ? L : L+1), 3-bit wrap.
//  - Output hold: out_* are stable while out_valid & !out_ready. ch_ack stays 0 during a stall.
//  - Error counter: +1 on the edge where a result with out_error=1 is loaded into stage 2.
//    Saturates at 2^CNT_W-1.
//    cnt_clr has priority over a simultaneous increment; the result is 0.
//  - ch_req dropped without an ack has no effect. ch_req held after ack is a new request.
//  - rst mid-transfer discards stage 1 and stage 2 contents. No ack is re-issued.
// CONFIGURATION
//  - TDC_ENC_ERRCNT_EN defined: per-channel counters, cnt_clr and err_cnt are functional.
//  - Not defined: no counter flops; err_cnt is tied to 0; cnt_clr is ignored.
// STRUCTURE
//  - Package tdc_enc_pkg holds:
//    - the FSM state typedef {IDLE, RUN, DRAIN} (2-bit);
//    - the result struct typedef {ch, code[2:0], bubble, error};
//    - constant THERM_W=8 and the default lvl value 1.
//  - One sub-module: the existing encode8b3b cell, instantiated once on stage 1.
//    Arbiter, FSM, pipeline and counters stay in this module.
// TESTING
//  - Single request: lvl=3, ch2 code=8'h10 -> ack[2] one cycle, then out ch=2, code=4, bubble=0, err=0, 2 cycles after req.
//  - Bubble / wrap cases:
//    - 8'h18, lvl=2 -> code=3, bubble=1, err=0.
//    - 8'h70, lvl=3 -> code=5, bubble=1.
//    - 8'h81, lvl=3 -> code=0, err=1, err_cnt[ch]+1.
//  - Fairness: all 4 req held for 8 grants -> ack order 0,1,2,3,0,1,2,3, one per cycle, with out_ready=1.
//  - Backpressure: out_ready=0 for 5 cycles with 2 requests pending -> out_* stable, no ack. Release -> both delivered in order, none lost.
//  - Drain and level handling:
//    - enable falls with stage 1 occupied -> result still delivered, then IDLE, no further acks.
//    - level=0 at start -> behaves as lvl=1: 8'h18 gives err=1.
//  - Counters (macro defined): 300 error results with CNT_W=8 -> err_cnt=255. cnt_clr coinciding with an error -> 0.
//    Macro undefined -> err_cnt is always 0.

Source files
------------

// File: rtl/tdc_enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_enc_pkg
//  Description : Shared types and constants for the TDC fine-code encoder
//                arbiter: FSM state encoding, result record, code width and
//                the default error threshold.
//  Revision    : 1.0 - initial release
// ============================================================================
package tdc_enc_pkg;

    // Width of one thermometer fine code
    localparam int THERM_W = 8;

    // Threshold used after reset and whenever the level input reads 0
    localparam logic [1:0] LVL_DEFAULT = 2'd1;

    // Widest channel index supported (N_CH up to 16)
    localparam int CH_W_MAX = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [CH_W_MAX-1:0] ch;
        logic [2:0]          code;
        logic                bubble;
        logic                error;
    } result_t;

endpackage
`default_nettype wire

// File: rtl/tdc_enc_arbiter_encode8b3b.sv
`default_nettype none
// ============================================================================
//  Module      : encode8b3b
//  Description : Combinational 8b thermometer -> 3b fine-code encoder with
//                bubble detection and an error flag when the spread between
//                the highest and lowest set bit reaches the threshold.
//  Revision    : 1.0 - initial release
// ============================================================================
module encode8b3b
    import tdc_enc_pkg::*;
(
    input  logic [THERM_W-1:0] therm_i,
    input  logic [1:0]         lvl_i,
    output logic [2:0]         code_o,
    output logic               bubble_o,
    output logic               error_o
);

    logic [2:0] w_hi;
    logic [2:0] w_lo;
    logic [2:0] w_dist;

    // Locate highest/lowest set bits, derive the modulo-8 spread and the code
    always_comb begin
        w_hi = 3'd0;
        for (int i = 1; i < THERM_W; i++) begin
            if (therm_i[i]) w_hi = i[2:0];
        end
        w_lo = 3'd7;
        for (int i = THERM_W - 2; i >= 0; i--) begin
            if (therm_i[i]) w_lo = i[2:0];
        end
        // Subtraction wraps naturally in 3 bits
        w_dist   = w_hi - w_lo;
        error_o  = (w_dist >= {1'b0, lvl_i});
        bubble_o = (w_dist != 3'd0);
        if (error_o)
            code_o = 3'd0;
        else if (w_dist <= 3'd1)
            code_o = w_lo;
        else
            code_o = w_lo + 3'd1;
    end

endmodule
`default_nettype wire

// File: rtl/tdc_enc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_enc_arbiter
//  Description : Round-robin sharing of one encode8b3b cell between N_CH
//                fine-code requesters. Two-stage pipeline (capture, output)
//                with valid/ready backpressure and per-channel saturating
//                error counters.
//  Build macro : TDC_ENC_ERRCNT_EN - when defined, error counters, cnt_clr
//                and err_cnt are live; otherwise err_cnt reads 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdc_enc_arbiter
    import tdc_enc_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CH_W  = $clog2(N_CH),
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [1:0]              level,
    input  logic [N_CH-1:0]         ch_req,
    input  logic [THERM_W*N_CH-1:0] ch_code,
    output logic [N_CH-1:0]         ch_ack,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH_W-1:0]         out_ch,
    output logic [2:0]              out_code,
    output logic                    out_bubble,
    output logic                    out_error,
    input  logic                    cnt_clr,
    output logic [N_CH*CNT_W-1:0]   err_cnt
);

    state_e               state_q;
    logic [1:0]           lvl_q;
    logic [CH_W-1:0]      ptr_q;
    logic                 s1_vld_q;
    logic [CH_W-1:0]      s1_ch_q;
    logic [THERM_W-1:0]   s1_code_q;
    logic                 out_valid_q;
    result_t              out_q;

    logic                 w_adv;
    logic                 w_load;
    logic                 w_gnt_found;
    logic [CH_W-1:0]      w_gnt_idx;
    logic                 w_grant;
    logic [2:0]           w_enc_code;
    logic                 w_enc_bubble;
    logic                 w_enc_error;

    // Channel index offset positions after base, wrapping modulo N_CH
    function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int off);
        int s;
        s = (int'(base) + off) % N_CH;
        return s[CH_W-1:0];
    endfunction

    assign w_adv   = !out_valid_q || out_ready;
    assign w_load  = w_adv && s1_vld_q;
    assign w_grant = (state_q == RUN) && w_adv && w_gnt_found;

    // Round-robin search starting just after the last winner
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = ptr_q;
        for (int i = 1; i <= N_CH; i++) begin
            if (!w_gnt_found && ch_req[rr_idx(ptr_q, i)]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = rr_idx(ptr_q, i);
            end
        end
    end

    // Grant pulse coincides with the edge that captures the code
    assign ch_ack = w_grant ? ({{(N_CH-1){1'b0}}, 1'b1} << w_gnt_idx) : '0;

    // Control FSM; threshold is latched only on leaving IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lvl_q   <= LVL_DEFAULT;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= RUN;
                        lvl_q   <= (level == 2'd0) ? LVL_DEFAULT : level;
                    end
                end
                RUN: begin
                    if (!enable) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (enable)
                        state_q <= RUN;
                    else if (!s1_vld_q && !out_valid_q)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Capture stage, output stage and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= CH_W'(N_CH - 1);
            s1_vld_q    <= 1'b0;
            s1_ch_q     <= '0;
            s1_code_q   <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            if (w_grant) begin
                ptr_q     <= w_gnt_idx;
                s1_vld_q  <= 1'b1;
                s1_ch_q   <= w_gnt_idx;
                s1_code_q <= ch_code[w_gnt_idx*THERM_W +: THERM_W];
            end else if (w_adv) begin
                s1_vld_q  <= 1'b0;
            end
            if (w_adv) begin
                out_valid_q <= s1_vld_q;
                if (s1_vld_q) begin
                    out_q.ch     <= CH_W_MAX'(s1_ch_q);
                    out_q.code   <= w_enc_code;
                    out_q.bubble <= w_enc_bubble;
                    out_q.error  <= w_enc_error;
                end
            end
        end
    end

    encode8b3b u_enc (
        .therm_i  (s1_code_q),
        .lvl_i    (lvl_q),
        .code_o   (w_enc_code),
        .bubble_o (w_enc_bubble),
        .error_o  (w_enc_error)
    );

    assign out_valid  = out_valid_q;
    assign out_ch     = out_q.ch[CH_W-1:0];
    assign out_code   = out_q.code;
    assign out_bubble = out_q.bubble;
    assign out_error  = out_q.error;

    // Upper index bits exist only for the widest channel count
    logic w_unused_out_ch;
    assign w_unused_out_ch = ^out_q.ch;

`ifdef TDC_ENC_ERRCNT_EN
    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q;
            // Saturating count of error results loaded into the output stage
            always_ff @(posedge clk) begin
                if (rst || cnt_clr)
                    cnt_q <= '0;
                else if (w_load && w_enc_error && (s1_ch_q == CH_W'(k)) &&
                         (cnt_q != {CNT_W{1'b1}}))
                    cnt_q <= cnt_q + CNT_W'(1);
            end
            assign err_cnt[k*CNT_W +: CNT_W] = cnt_q;
        end
    endgenerate
`else
    assign err_cnt = '0;
    logic w_unused_cnt;
    assign w_unused_cnt = cnt_clr ^ w_load;
`endif

endmodule
`default_nettype wire
